game_round_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 37 +++
 rtl/note_lfsr.sv | 35 +++
 rtl/game_round_sequencer.sv | 164 ++++++++++++++++
 tb/tb_game_round_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ------------------------------------------------------------------------
// game_pkg: shared types and constants for the keypad memory game sequencer.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  localparam int NOTE_W = 4;
  localparam int LFSR_W = 16;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [NOTE_W-1:0] NOTE_MIN = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_MAX = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_GEN     = 3'd2,
    ST_LOAD    = 3'd3,
    ST_START   = 3'd4,
    ST_PLAY    = 3'd5,
    ST_WIN     = 3'd6,
    ST_TIMEOUT = 3'd7
  } seq_state_t;

  function automatic logic [NOTE_W-1:0] next_note_wrap(input logic [NOTE_W-1:0] n);
    return (n == NOTE_MAX) ? NOTE_MIN : n + NOTE_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_lfsr.sv
// ------------------------------------------------------------------------
// note_lfsr: 16-bit Fibonacci LFSR with a note output in the range 1..8.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module note_lfsr
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  output logic [LFSR_W-1:0] state,
  output logic [NOTE_W-1:0] note
);

  logic feedback;

  assign feedback = state[TAP_A] ^ state[TAP_B] ^ state[TAP_C] ^ state[TAP_D];
  // Only the low three bits select the note, offset so that 0 never appears.
  assign note     = {1'b0, state[2:0]} + NOTE_MIN;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[LFSR_W-2:0], feedback};
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_round_sequencer.sv
// ------------------------------------------------------------------------
// game_round_sequencer: round controller (clear, melody gen, load, start, supervise).
// Optional build macro SEQ_NO_REPEAT_EN suppresses equal adjacent notes. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module game_round_sequencer
  import game_pkg::*;
#(
  parameter int                NOTE_COUNT     = 8,
  parameter int                TIMEOUT_CYCLES = 50_000_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_req,
  input  logic                         abort,
  input  logic                         game_end,
  input  logic                         miss_in,
  output logic [NOTE_W*NOTE_COUNT-1:0] data_out,
  output logic                         write_enable,
  output logic                         game_start,
  output logic                         game_clear,
  output logic                         busy,
  output logic                         win_pulse,
  output logic                         timeout_flag,
  output logic [7:0]                   round_count,
  output logic [7:0]                   miss_count
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam int IDX_W   = (NOTE_COUNT > 1) ? $clog2(NOTE_COUNT) : 1;

  seq_state_t          state;
  logic                start_q;
  logic                miss_q;
  logic [TIMER_W-1:0]  timer;
  logic [IDX_W-1:0]    gen_idx;
  logic                start_edge;
  logic                miss_edge;
  logic                lfsr_adv;
  logic [NOTE_W-1:0]   raw_note;
  logic [NOTE_W-1:0]   gen_note;
  logic [LFSR_W-1:0]   lfsr_unused;

  assign start_edge = start_req & ~start_q;
  assign miss_edge  = miss_in & ~miss_q;
  assign lfsr_adv   = (state == ST_GEN) && !abort;

  note_lfsr #(
    .SEED (LFSR_SEED)
  ) u_note_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (lfsr_adv),
    .state   (lfsr_unused),
    .note    (raw_note)
  );

`ifdef SEQ_NO_REPEAT_EN
  logic [NOTE_W-1:0] prev_note;
  logic [IDX_W-1:0]  prev_idx;

  assign prev_idx  = gen_idx - IDX_W'(1);
  assign prev_note = data_out[int'(prev_idx)*NOTE_W +: NOTE_W];
  assign gen_note  = ((gen_idx != '0) && (raw_note == prev_note)) ? next_note_wrap(raw_note)
                                                                   : raw_note;
`else
  assign gen_note  = raw_note;
`endif

  // Strobes default low every cycle; each is raised on the transition into its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      start_q      <= 1'b0;
      miss_q       <= 1'b0;
      timer        <= '0;
      gen_idx      <= '0;
      data_out     <= '0;
      write_enable <= 1'b0;
      game_start   <= 1'b0;
      game_clear   <= 1'b0;
      busy         <= 1'b0;
      win_pulse    <= 1'b0;
      timeout_flag <= 1'b0;
      round_count  <= 8'd0;
      miss_count   <= 8'd0;
    end else begin
      start_q      <= start_req;
      miss_q       <= miss_in;
      write_enable <= 1'b0;
      game_start   <= 1'b0;
      game_clear   <= 1'b0;
      win_pulse    <= 1'b0;

      if ((state != ST_IDLE) && abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_edge) begin
              state        <= ST_CLEAR;
              game_clear   <= 1'b1;
              busy         <= 1'b1;
              timeout_flag <= 1'b0;
              miss_count   <= 8'd0;
            end
          end
          ST_CLEAR: begin
            data_out <= '0;
            gen_idx  <= '0;
            state    <= ST_GEN;
          end
          ST_GEN: begin
            data_out[int'(gen_idx)*NOTE_W +: NOTE_W] <= gen_note;
            if (gen_idx == IDX_W'(NOTE_COUNT - 1)) begin
              state        <= ST_LOAD;
              write_enable <= 1'b1;
            end else begin
              gen_idx <= gen_idx + IDX_W'(1);
            end
          end
          ST_LOAD: begin
            state      <= ST_START;
            game_start <= 1'b1;
          end
          ST_START: begin
            timer <= '0;
            state <= ST_PLAY;
          end
          ST_PLAY: begin
            timer <= timer + TIMER_W'(1);
            if (miss_edge && (miss_count != 8'hFF)) begin
              miss_count <= miss_count + 8'd1;
            end
            if (game_end) begin
              state     <= ST_WIN;
              win_pulse <= 1'b1;
              if (round_count != 8'hFF) begin
                round_count <= round_count + 8'd1;
              end
            end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
              state        <= ST_TIMEOUT;
              timeout_flag <= 1'b1;
            end
          end
          ST_WIN, ST_TIMEOUT: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_round_sequencer.sv
// ------------------------------------------------------------------------
// tb_game_round_sequencer: scoreboard bench for game_round_sequencer.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_game_round_sequencer;

  localparam int          NC   = 8;
  localparam int          TMO  = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int K_CLEAR = 0;
  localparam int K_LOAD  = 1;
  localparam int K_START = 2;
  localparam int K_WIN   = 3;
  localparam int K_TMO   = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start_req;
  logic        abort;
  logic        game_end;
  logic        miss_in;
  logic [31:0] data_out;
  logic        write_enable;
  logic        game_start;
  logic        game_clear;
  logic        busy;
  logic        win_pulse;
  logic        timeout_flag;
  logic [7:0]  round_count;
  logic [7:0]  miss_count;

  exp_t        expq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic        tmo_q = 1'b0;
  logic [15:0] m_lfsr;
  int          m_rounds;

  game_round_sequencer #(
    .NOTE_COUNT     (NC),
    .TIMEOUT_CYCLES (TMO),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_req    (start_req),
    .abort        (abort),
    .game_end     (game_end),
    .miss_in      (miss_in),
    .data_out     (data_out),
    .write_enable (write_enable),
    .game_start   (game_start),
    .game_clear   (game_clear),
    .busy         (busy),
    .win_pulse    (win_pulse),
    .timeout_flag (timeout_flag),
    .round_count  (round_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_CLEAR: return "game_clear";
      K_LOAD:  return "write_enable";
      K_START: return "game_start";
      K_WIN:   return "win_pulse";
      default: return "timeout_flag";
    endcase
  endfunction

  // Reference melody: the next NC notes drawn from the model LFSR.
  function automatic logic [31:0] gen_melody();
    logic [31:0] mel;
    logic [3:0]  n;
    logic [3:0]  prev;
    mel  = '0;
    prev = '0;
    for (int k = 0; k < NC; k++) begin
      n = 4'(m_lfsr % 8) + 4'd1;
`ifdef SEQ_NO_REPEAT_EN
      if (k > 0 && n == prev) n = (n == 4'd8) ? 4'd1 : n + 4'd1;
`endif
      mel[k*4 +: 4] = n;
      prev = n;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    return mel;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_event(input int kind, input logic [31:0] val);
    exp_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s at cycle %0d: got a strobe, expected none", kname(kind), cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
        fails++;
        $display("FAIL event_%s: got %s cycle %0d value %0h, expected %s cycle %0d value %0h",
                 kname(e.kind), kname(kind), cyc, val, kname(e.kind), e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (game_clear)   check_event(K_CLEAR, 32'd0);
      if (write_enable) check_event(K_LOAD, data_out);
      if (game_start)   check_event(K_START, 32'd0);
      if (win_pulse)    check_event(K_WIN, {24'd0, round_count});
      if (timeout_flag && !tmo_q) check_event(K_TMO, 32'd1);
    end
    tmo_q = timeout_flag;
  end

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] val);
    expq.push_back('{kind, c, val});
  endtask

  // mode 0: win at a random PLAY cycle, 1: timeout, 2: win on the last timer cycle.
  task automatic run_round(input int mode, input int nmiss, input bit chk42);
    int          c0;
    int          ps;
    int          tend;
    logic [31:0] mel;
    bit          in_range;
    to_cycle(cyc + 2);
    c0        = cyc;
    start_req = 1'b1;
    mel       = gen_melody();
    push(K_CLEAR, c0 + 1, 32'd0);
    push(K_LOAD, c0 + NC + 2, mel);
    push(K_START, c0 + NC + 3, 32'd0);
    to_cycle(c0 + 1);
    start_req = 1'b0;
    check("busy_on", {31'd0, busy}, 32'd1);
    check("timeout_clr", {31'd0, timeout_flag}, 32'd0);
    check("miss_clr", {24'd0, miss_count}, 32'd0);
    to_cycle(c0 + NC + 2);
    in_range = 1'b1;
    for (int k = 0; k < NC; k++) begin
      if (data_out[k*4 +: 4] < 4'd1 || data_out[k*4 +: 4] > 4'd8) in_range = 1'b0;
    end
    check("notes_in_range", {31'd0, in_range}, 32'd1);
    if (chk42) check("first_two_notes", {24'd0, data_out[7:0]}, 32'h42);
    ps = c0 + NC + 4;
    for (int i = 0; i < 11; i++) begin
      to_cycle(ps + 1 + i);
      miss_in   = (i < 2 * nmiss) && (i % 2 == 0);
      start_req = (i == 0);
    end
    to_cycle(ps + 12);
    check("miss_count", {24'd0, miss_count}, nmiss);
    if (mode == 1) begin
      push(K_TMO, ps + TMO, 32'd1);
      to_cycle(ps + TMO + 1);
      check("busy_after_timeout", {31'd0, busy}, 32'd0);
      check("timeout_sticky", {31'd0, timeout_flag}, 32'd1);
      check("rounds_after_timeout", {24'd0, round_count}, m_rounds);
    end else begin
      tend = (mode == 2) ? ps + TMO - 1 : ps + 12 + $urandom_range(0, 2);
      to_cycle(tend);
      game_end = 1'b1;
      m_rounds = (m_rounds == 255) ? 255 : m_rounds + 1;
      push(K_WIN, tend + 1, m_rounds);
      to_cycle(tend + 1);
      game_end = 1'b0;
      check("busy_in_win", {31'd0, busy}, 32'd1);
      to_cycle(tend + 2);
      check("busy_after_win", {31'd0, busy}, 32'd0);
      check("round_count", {24'd0, round_count}, m_rounds);
      check("no_timeout_on_win", {31'd0, timeout_flag}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset_n   = 1'b0;
    start_req = 1'b0;
    abort     = 1'b0;
    game_end  = 1'b0;
    miss_in   = 1'b0;
    m_lfsr    = SEED;
    m_rounds  = 0;
    to_cycle(3);
    check("rst_data_out", data_out, 32'd0);
    check("rst_strobes", {28'd0, write_enable, game_start, game_clear, win_pulse}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout_flag}, 32'd0);
    check("rst_counts", {16'd0, round_count, miss_count}, 32'd0);
    reset_n = 1'b1;

    run_round(0, 3, 1'b1);
    run_round(0, 0, 1'b0);
    run_round(1, 2, 1'b0);
    run_round(2, 1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      run_round($urandom_range(0, 2), $urandom_range(0, 5), 1'b0);
    end

    // Abort in GEN with game_end held high: no load, no win, counters kept.
    to_cycle(cyc + 2);
    c0        = cyc;
    game_end  = 1'b1;
    start_req = 1'b1;
    push(K_CLEAR, c0 + 1, 32'd0);
    to_cycle(c0 + 1);
    start_req = 1'b0;
    to_cycle(c0 + 5);
    abort = 1'b1;
    to_cycle(c0 + 6);
    abort = 1'b0;
    check("busy_after_abort", {31'd0, busy}, 32'd0);
    to_cycle(c0 + 20);
    game_end = 1'b0;
    check("rounds_after_abort", {24'd0, round_count}, m_rounds);

    // Reset in the middle of GEN returns everything to its initial state.
    to_cycle(cyc + 2);
    c0        = cyc;
    start_req = 1'b1;
    push(K_CLEAR, c0 + 1, 32'd0);
    to_cycle(c0 + 1);
    start_req = 1'b0;
    to_cycle(c0 + 5);
    reset_n = 1'b0;
    #1;
    check("busy_mid_reset", {31'd0, busy}, 32'd0);
    check("rounds_mid_reset", {24'd0, round_count}, 32'd0);
    check("data_mid_reset", data_out, 32'd0);
    to_cycle(c0 + 7);
    reset_n  = 1'b1;
    m_lfsr   = SEED;
    m_rounds = 0;
    run_round(0, 4, 1'b1);

    to_cycle(cyc + 10);
    check("scoreboard_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
